// File: rtl/odata_pool_rd_sched_if.sv
// Bundle of requester, pool-request and pool-completion signals shared by the
// read scheduler (slave view) and whatever drives it (master view).
interface odata_pool_rd_sched_if #(
  parameter int NUM  = 4,
  parameter int EX_W = 32
);
  logic [NUM-1:0]    req_valid;
  logic [NUM-1:0]    req_ready;
  logic [NUM*32-1:0] req_addr;
  logic [NUM*32-1:0] req_size;
  logic [NUM-1:0]    req_done;
  logic              pool_valid;
  logic              pool_ready;
  logic [63:0]       pool_data;
  logic [EX_W-1:0]   pool_ex_info;
  logic              done_valid;
  logic [EX_W-1:0]   done_ex_info;
  logic              busy;
  logic [3:0]        outstanding;

  modport master (
    output req_valid, req_addr, req_size, pool_ready, done_valid, done_ex_info,
    input  req_ready, req_done, pool_valid, pool_data, pool_ex_info, busy, outstanding
  );

  modport slave (
    input  req_valid, req_addr, req_size, pool_ready, done_valid, done_ex_info,
    output req_ready, req_done, pool_valid, pool_data, pool_ex_info, busy, outstanding
  );
endinterface

// File: rtl/odata_pool_rd_sched.sv
// Round-robin read-request scheduler: splits {addr,size} requests into
// burst/4KB-legal segments for the odata pool and tracks their completion.
module odata_pool_rd_sched #(
  parameter int NUM       = 4,
  parameter int BYTES     = 8,
  parameter int MAX_BEATS = 256,
  parameter int MAX_OUT   = 4,
  parameter int EX_W      = 32
) (
  input logic clock,
  input logic rst,
  odata_pool_rd_sched_if.slave bus
);
  localparam int IDW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int BSH = $clog2(BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [1:0]     r_state;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] r_cur_id;
  logic [31:0]    r_cur_addr;
  logic [31:0]    r_rem;
  logic [31:0]    r_seg;
  logic           r_last_seg;
  logic [3:0]     r_out;
  logic [NUM-1:0] r_done;

  logic           w_grant_found;
  logic [IDW-1:0] w_grant_id;
  logic [IDW-1:0] w_cand;
  logic           w_accept;
  logic [31:0]    w_sel_addr;
  logic [31:0]    w_sel_size;
  logic [12:0]    w_bnd;
  logic [31:0]    w_seg_calc;
  logic           w_pool_valid;
  logic           w_hs;
  logic           w_dec;
  logic [NUM-1:0] w_done_next;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_cand        = '0;
    for (int k = 1; k <= NUM; k++) begin
      w_cand = IDW'((int'(r_last_grant) + k) % NUM);
      if (!w_grant_found && bus.req_valid[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_cand;
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_grant_found && !rst;

  always_comb begin
    w_sel_addr = '0;
    w_sel_size = '0;
    for (int i = 0; i < NUM; i++) begin
      if (w_grant_id == IDW'(i)) begin
        w_sel_addr = bus.req_addr[32*i +: 32];
        w_sel_size = bus.req_size[32*i +: 32];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      bus.req_ready[i] = w_accept && (w_grant_id == IDW'(i));
    end
  end

  // Beats left before the next 4 KB page; address is already beat-aligned.
  assign w_bnd = (13'd4096 - {1'b0, r_cur_addr[11:0]}) >> BSH;

  always_comb begin
    w_seg_calc = r_rem;
    if (w_seg_calc > 32'(MAX_BEATS)) w_seg_calc = 32'(MAX_BEATS);
    if (w_seg_calc > {19'd0, w_bnd}) w_seg_calc = {19'd0, w_bnd};
  end

  assign w_pool_valid = (r_state == S_ISSUE) && (r_out < 4'(MAX_OUT));
  assign w_hs         = w_pool_valid && bus.pool_ready;
  assign w_dec        = bus.done_valid && (r_out != 4'd0);

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      w_done_next[i] = (w_accept && (w_sel_size == 32'd0) && (w_grant_id == IDW'(i))) ||
                       (w_dec && bus.done_ex_info[IDW] &&
                        (bus.done_ex_info[IDW-1:0] == IDW'(i)));
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDW'(NUM - 1);
      r_cur_id     <= '0;
      r_cur_addr   <= '0;
      r_rem        <= '0;
      r_seg        <= '0;
      r_last_seg   <= 1'b0;
      r_out        <= '0;
      r_done       <= '0;
    end else begin
      r_done <= w_done_next;
      case ({w_hs, w_dec})
        2'b10:   r_out <= r_out + 4'd1;
        2'b01:   r_out <= r_out - 4'd1;
        default: r_out <= r_out;
      endcase
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_grant_id;
            r_cur_id     <= w_grant_id;
            r_cur_addr   <= w_sel_addr & ~32'(BYTES - 1);
            r_rem        <= w_sel_size;
            if (w_sel_size != 32'd0) r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_seg      <= w_seg_calc;
          r_last_seg <= (w_seg_calc == r_rem);
          r_state    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_hs) begin
            r_cur_addr <= r_cur_addr + (r_seg << BSH);
            r_rem      <= r_rem - r_seg;
            r_state    <= r_last_seg ? S_IDLE : S_CALC;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.pool_ex_info          = '0;
    bus.pool_ex_info[IDW:0]   = {r_last_seg, r_cur_id};
  end

  assign bus.pool_valid  = w_pool_valid;
  assign bus.pool_data   = {r_cur_addr, r_seg};
  assign bus.req_done    = r_done;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.outstanding = r_out;

  // A completion with nothing in flight means the pool and scheduler disagree.
  assert property (@(posedge clock) disable iff (rst) !(bus.done_valid && (r_out == 4'd0)));
endmodule
